// File: rtl/button_gesture_ctrl.sv
// button_gesture_ctrl
// Classifies presses of a debounced, active-low button as single click,
// double click or long press. Each classified gesture goes into a
// one-entry output register that uses a valid/ready handshake.
//
// Ports:
//   clk          system clock; all logic runs on its rising edge
//   rst          synchronous, active-high reset
//   btn_n        debounced, synchronized button level (0 = pressed)
//   event_ready  consumer accepts the pending event this cycle
//   event_valid  event_code holds an unconsumed event
//   event_code   01 single, 10 double, 11 long
//   overflow     sticky flag: an event was dropped because one was already pending
//   busy         FSM is not in IDLE
module button_gesture_ctrl #(
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       event_ready,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       overflow,
    output logic       busy
);

    localparam int unsigned MaxCycles = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles);

    localparam logic [CntW-1:0] LongLast = CntW'(LONG_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPress1 = 3'd1;
    localparam logic [2:0] StHold   = 3'd2;
    localparam logic [2:0] StGap    = 3'd3;
    localparam logic [2:0] StPress2 = 3'd4;

    localparam logic [1:0] EvSingle = 2'b01;
    localparam logic [1:0] EvDouble = 2'b10;
    localparam logic [1:0] EvLong   = 2'b11;

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            valid_q, valid_d;
    logic [1:0]      code_q, code_d;
    logic            ovf_q, ovf_d;

    logic            emit;
    logic [1:0]      emit_code;
    logic            handshake;

    // Gesture classifier
    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_code = EvSingle;
        case (state_q)
            StIdle: begin
                if (!btn_n) state_d = StPress1;
            end
            StPress1: begin
                // Release takes priority over the long-press terminal count.
                if (btn_n) begin
                    state_d = StGap;
                end else if (cnt_q == LongLast) begin
                    state_d   = StHold;
                    emit      = 1'b1;
                    emit_code = EvLong;
                end
            end
            StHold: begin
                if (btn_n) state_d = StIdle;
            end
            StGap: begin
                // A second press in the terminal cycle still counts as a double.
                if (!btn_n) begin
                    state_d = StPress2;
                end else if (cnt_q == GapLast) begin
                    state_d   = StIdle;
                    emit      = 1'b1;
                    emit_code = EvSingle;
                end
            end
            StPress2: begin
                if (btn_n) begin
                    state_d   = StIdle;
                    emit      = 1'b1;
                    emit_code = EvDouble;
                end
            end
            default: state_d = StIdle;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // One-entry output register; the FSM never waits on the consumer.
    always_comb begin
        handshake = valid_q & event_ready;
        valid_d   = valid_q;
        code_d    = code_q;
        ovf_d     = ovf_q;
        if (emit && (!valid_q || handshake)) begin
            valid_d = 1'b1;
            code_d  = emit_code;
        end else if (emit) begin
            ovf_d = 1'b1;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 2'b00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign event_valid = valid_q;
    assign event_code  = code_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// Scoreboard bench for button_gesture_ctrl with LONG_CYCLES=8, GAP_CYCLES=5.
// Stimulus pushes the expected code and the cycle in which it should be
// accepted (-1 = any cycle); a monitor pops and compares each handshake.
module tb_button_gesture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_n;
    logic       event_ready;
    logic       event_valid;
    logic [1:0] event_code;
    logic       overflow;
    logic       busy;

    typedef struct {
        logic [1:0] code;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

    button_gesture_ctrl #(
        .LONG_CYCLES(8),
        .GAP_CYCLES (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_n      (btn_n),
        .event_ready(event_ready),
        .event_valid(event_valid),
        .event_code (event_code),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed handshake must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_event: got code %0d at cycle %0d, none expected",
                         event_code, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_code", int'(event_code), int'(e.code));
                if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        rst         = 1'b1;
        btn_n       = 1'b1;
        event_ready = 1'b1;
        tick(2);
        check("rst_valid", int'(event_valid), 0);
        check("rst_code", int'(event_code), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick(2);

        // Short press followed by a long release: single click.
        btn_n = 1'b0;
        tick(3);
        btn_n = 1'b1;
        push(2'b01, cyc + 6);
        tick(12);
        check("single_busy_idle", int'(busy), 0);

        // Two short presses: double click only.
        btn_n = 1'b0;
        tick(3);
        btn_n = 1'b1;
        tick(2);
        btn_n = 1'b0;
        tick(3);
        btn_n = 1'b1;
        push(2'b10, cyc + 1);
        tick(10);
        check("double_busy_idle", int'(busy), 0);

        // Held press: long, then silence until release.
        btn_n = 1'b0;
        push(2'b11, cyc + 9);
        tick(4);
        check("long_busy_pressed", int'(busy), 1);
        tick(16);
        btn_n = 1'b1;
        check("long_busy_at_release", int'(busy), 1);
        tick(1);
        check("long_busy_after_release", int'(busy), 0);
        tick(10);

        // Release exactly at the long terminal count: release wins.
        btn_n = 1'b0;
        tick(8);
        btn_n = 1'b1;
        push(2'b01, cyc + 6);
        tick(12);

        // Backpressure: single pending, then a long that must be dropped.
        event_ready = 1'b0;
        btn_n       = 1'b0;
        tick(3);
        btn_n = 1'b1;
        tick(8);
        check("bp_valid_single", int'(event_valid), 1);
        check("bp_no_overflow_yet", int'(overflow), 0);
        btn_n = 1'b0;
        tick(12);
        check("bp_valid", int'(event_valid), 1);
        check("bp_code_kept", int'(event_code), 1);
        check("bp_overflow", int'(overflow), 1);
        btn_n = 1'b1;
        tick(2);
        push(2'b01, -1);
        event_ready = 1'b1;
        tick(1);
        check("bp_valid_cleared", int'(event_valid), 0);
        check("bp_overflow_sticky", int'(overflow), 1);
        tick(3);

        // Reset during HOLD with an event pending, button still pressed.
        event_ready = 1'b0;
        btn_n       = 1'b0;
        tick(12);
        check("hold_pending", int'(event_valid), 1);
        check("hold_busy", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_valid", int'(event_valid), 0);
        check("mid_rst_code", int'(event_code), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        check("mid_rst_busy", int'(busy), 0);
        rst         = 1'b0;
        event_ready = 1'b1;
        c           = cyc;
        tick(1);
        check("post_rst_busy", int'(busy), 1);
        push(2'b11, c + 9);
        tick(10);
        btn_n = 1'b1;
        tick(3);
        check("final_busy", int'(busy), 0);

        tick(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
